// File: rtl/mux_scan_reg.sv
// rtl/mux_scan_reg.sv - CH:1 registered mux with direct select and round-robin scan, valid/ready output
module mux_scan_reg #(
  parameter int WIDTH   = 8,
  parameter int CH      = 8,
  parameter int SELW    = 3,
  parameter int DWELL_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [SELW-1:0]     sel,
  input  logic [CH-1:0]       ch_mask,
  input  logic [DWELL_W-1:0]  dwell,
  input  logic [CH*WIDTH-1:0] din,
  output logic [WIDTH-1:0]    dout,
  output logic [SELW-1:0]     dout_ch,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                sel_err
);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  localparam logic [SELW:0]   CH_W    = (SELW+1)'(CH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(CH - 1);

  state_t             state, state_nxt;
  logic [SELW-1:0]    ptr, ptr_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_nxt;
  logic [DWELL_W-1:0] dwell_eff;
  logic [DWELL_W:0]   run_len;
  logic [SELW-1:0]    scan_ch, cap_ch;
  logic               free, capture, found, sel_bad, err_nxt;
  int                 idx;

  assign free      = ~dout_valid | dout_ready;
  assign sel_bad   = {1'b0, sel} >= CH_W;
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // First enabled channel at or after ptr, wrapping at CH (never yields an index >= CH)
  always_comb begin
    found   = 1'b0;
    scan_ch = '0;
    idx     = 0;
    for (int i = 0; i < CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CH) idx = idx - CH;
      if (!found && ch_mask[idx]) begin
        found   = 1'b1;
        scan_ch = idx[SELW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    capture       = 1'b0;
    cap_ch        = sel;
    err_nxt       = 1'b0;
    ptr_nxt       = ptr;
    dwell_cnt_nxt = dwell_cnt;
    run_len       = '0;
    case (state)
      DIRECT: begin
        err_nxt = sel_bad;
        capture = en & free & ~sel_bad;
      end
      SCAN: begin
        err_nxt = ~found;
        cap_ch  = scan_ch;
        capture = en & free & found;
        // A channel reached by skipping a masked ptr starts a fresh dwell
        run_len = ((scan_ch == ptr) ? {1'b0, dwell_cnt} : '0) + (DWELL_W+1)'(1);
        if (capture) begin
          if (run_len >= {1'b0, dwell_eff}) begin
            ptr_nxt       = (scan_ch == LAST_CH) ? '0 : scan_ch + SELW'(1);
            dwell_cnt_nxt = '0;
          end else begin
            ptr_nxt       = scan_ch;
            dwell_cnt_nxt = run_len[DWELL_W-1:0];
          end
        end
      end
      default: ;
    endcase

    if (!en)       state_nxt = IDLE;
    else if (mode) state_nxt = SCAN;
    else           state_nxt = DIRECT;

    if (state_nxt == SCAN && state != SCAN) begin
      ptr_nxt       = '0;
      dwell_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      dwell_cnt  <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      sel_err   <= err_nxt;
      if (capture) begin
        dout       <= din[int'(cap_ch)*WIDTH +: WIDTH];
        dout_ch    <= cap_ch;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb/tb_mux_scan_reg.sv - self-checking bench for mux_scan_reg against a cycle reference model
module tb_mux_scan_reg;
  localparam int WIDTH = 8, CH = 10, SELW = 4, DWELL_W = 4;

  logic                clk = 1'b0;
  logic                rst, en, mode, dout_ready;
  logic [SELW-1:0]     sel;
  logic [CH-1:0]       ch_mask;
  logic [DWELL_W-1:0]  dwell;
  logic [CH*WIDTH-1:0] din;
  logic [WIDTH-1:0]    dout;
  logic [SELW-1:0]     dout_ch;
  logic                dout_valid, sel_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: 0 idle, 1 direct, 2 scan
  int             m_state, m_ptr, m_cnt, m_ch;
  logic [WIDTH-1:0] m_dout;
  logic           m_valid, m_err;

  int exp_seq[10] = '{0, 0, 2, 2, 5, 5, 7, 7, 0, 0};

  mux_scan_reg #(.WIDTH(WIDTH), .CH(CH), .SELW(SELW), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .ch_mask(ch_mask),
    .dwell(dwell), .din(din), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_cnt = 0; m_ch = 0;
    m_dout = '0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step();
    int  c, run, d, nxt;
    bit  cap;
    cap = 0;
    c   = 0;
    if (m_state == 1) begin
      if (int'(sel) < CH) begin cap = 1; c = int'(sel); end
    end else if (m_state == 2) begin
      for (int k = CH - 1; k >= 0; k--)
        if (ch_mask[(m_ptr + k) % CH]) c = (m_ptr + k) % CH;
      cap = (ch_mask != '0);
    end
    m_err = (m_state == 1 && int'(sel) >= CH) || (m_state == 2 && ch_mask == '0);
    cap = cap && en && (!m_valid || dout_ready);
    if (cap && m_state == 2) begin
      run = (c == m_ptr) ? m_cnt + 1 : 1;
      d   = (dwell == '0) ? 1 : int'(dwell);
      if (run >= d) begin m_ptr = (c + 1) % CH; m_cnt = 0; end
      else begin m_ptr = c; m_cnt = run; end
    end
    nxt = !en ? 0 : (mode ? 2 : 1);
    if (nxt == 2 && m_state != 2) begin m_ptr = 0; m_cnt = 0; end
    m_state = nxt;
    if (cap) begin
      m_dout  = din[c*WIDTH +: WIDTH];
      m_ch    = c;
      m_valid = 1'b1;
    end else if (dout_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("dout", dout, m_dout);
    check("dout_ch", dout_ch, m_ch);
    check("dout_valid", dout_valid, m_valid);
    check("sel_err", sel_err, m_err);
  endtask

  task automatic randomize_din();
    for (int n = 0; n < CH; n++) din[n*WIDTH +: WIDTH] = WIDTH'($urandom);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; ch_mask = '0; dwell = '0;
    dout_ready = 1'b0; din = '0;
    model_reset();
    #1 rst = 1'b1;
    #11;
    check("rst_dout", dout, 0);
    check("rst_ch", dout_ch, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_err", sel_err, 0);
    rst = 1'b0;

    // Direct mode
    randomize_din();
    din[5*WIDTH +: WIDTH] = 8'hA5;
    en = 1'b1; mode = 1'b0; sel = 4'd5; dout_ready = 1'b1;
    cycle();
    check("idle_no_valid", dout_valid, 0);
    cycle();
    check("direct_dout", dout, 8'hA5);
    check("direct_ch", dout_ch, 5);
    sel = 4'd9;
    cycle();
    check("direct_ch9", dout_ch, 9);
    sel = 4'd10;
    cycle();
    check("sel_err_hi", sel_err, 1);
    check("sel_err_novalid", dout_valid, 0);

    // Scan with dwell 2 and wrap
    mode = 1'b1; ch_mask = 10'b00_1010_0101; dwell = 4'd2;
    cycle();
    for (int i = 0; i < 10; i++) begin
      randomize_din();
      cycle();
      check($sformatf("scan_seq%0d", i), dout_ch, exp_seq[i]);
    end

    // Backpressure freezes output and pointer
    dout_ready = 1'b0;
    repeat (4) begin
      randomize_din();
      cycle();
      check("bp_hold_ch", dout_ch, 0);
      check("bp_hold_valid", dout_valid, 1);
    end
    dout_ready = 1'b1;
    cycle();
    check("bp_next_ch", dout_ch, 2);

    // Empty mask
    ch_mask = '0;
    cycle();
    check("mask0_err", sel_err, 1);
    check("mask0_valid", dout_valid, 0);

    // Mask change mid-dwell
    dwell = 4'd3; ch_mask = 10'b00_1010_0101;
    cycle();
    check("middwell_ch2", dout_ch, 2);
    ch_mask = 10'h010;
    cycle();
    check("mask_ch4", dout_ch, 4);

    // Scan -> direct -> scan
    mode = 1'b0; sel = 4'd3;
    cycle();
    cycle();
    check("to_direct_ch3", dout_ch, 3);
    mode = 1'b1; ch_mask = 10'b00_1010_0100;
    cycle();
    cycle();
    check("rescan_lowest", dout_ch, 2);

    // en low while stalled
    dout_ready = 1'b0; en = 1'b0;
    repeat (3) begin
      cycle();
      check("en0_hold_valid", dout_valid, 1);
      check("en0_hold_ch", dout_ch, 2);
    end
    dout_ready = 1'b1;
    cycle();
    check("en0_drain", dout_valid, 0);

    // Asynchronous reset mid-stream
    en = 1'b1; mode = 1'b1; ch_mask = '1; dwell = 4'd1;
    cycle();
    cycle();
    check("pre_rst_valid", dout_valid, 1);
    #3 rst = 1'b1;
    #1;
    check("arst_dout", dout, 0);
    check("arst_ch", dout_ch, 0);
    check("arst_valid", dout_valid, 0);
    check("arst_err", sel_err, 0);
    model_reset();
    en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    check("post_rst_idle", dout_valid, 0);
    en = 1'b1;
    cycle();
    cycle();
    check("post_rst_ch0", dout_ch, 0);

    // Randomized traffic against the model
    for (int t = 0; t < 600; t++) begin
      randomize_din();
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      sel = SELW'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0)
        ch_mask = ($urandom_range(0, 4) == 0) ? '0 : CH'($urandom);
      if ($urandom_range(0, 11) == 0) dwell = DWELL_W'($urandom);
      dout_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
